// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared types and constants for the multiport register file slice.
//   - reg_addr_t / reg_data_t : default-width address and data types
//   - ZERO_REG                : hardwired-zero register index
//   - DEF_SP_IDX / DEF_SP_RESET : default stack-pointer index and reset value
//   - wr_winner()             : write-port priority resolution (highest index wins)
package regfile_pkg;

   localparam int unsigned DEF_N_REG_ADDR = 5;
   localparam int unsigned DEF_N_REG      = 32;
   localparam int unsigned DEF_N_DATA     = 32;
   localparam int unsigned DEF_SP_IDX     = 2;
   localparam int unsigned DEF_SP_RESET   = 255;

   // Upper bound on write ports handled by the priority function.
   localparam int unsigned MAX_WR_PORTS   = 32;

   typedef logic [DEF_N_REG_ADDR-1:0] reg_addr_t;
   typedef logic [DEF_N_DATA-1:0]     reg_data_t;

   localparam reg_addr_t ZERO_REG = '0;

   // Index of the highest set bit in the hit mask; the caller only uses the
   // result when the mask is non-zero.
   function automatic int unsigned wr_winner(input logic [MAX_WR_PORTS-1:0] hits);
      int unsigned w;
      w = 0;
      for (int unsigned p = 0; p < MAX_WR_PORTS; p++) begin
         if (hits[p]) w = p;
      end
      return w;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Per-register busy bits for long-latency results.
//   Ports:
//     clk_i       clock
//     rst_i       synchronous active-high reset, clears all busy bits
//     rsv_en_i    reserve request (sets busy of rsv_addr_i at the edge)
//     rsv_addr_i  register to reserve (register 0 ignored)
//     wr_clr_i    per-register clear from enabled writes (index 1..N_REG-1)
//     rd_addr_i   flattened read addresses, N_READ x N_REG_ADDR
//     rd_busy_o   busy bit of each addressed register (0 for reg 0 / out of range)
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned N_REG_ADDR = DEF_N_REG_ADDR,
   parameter int unsigned N_REG      = DEF_N_REG,
   parameter int unsigned N_READ     = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         rsv_en_i,
   input  logic [N_REG_ADDR-1:0]        rsv_addr_i,
   input  logic [N_REG-1:1]             wr_clr_i,
   input  logic [N_READ*N_REG_ADDR-1:0] rd_addr_i,
   output logic [N_READ-1:0]            rd_busy_o
);

   logic [N_REG-1:1] busy_q;
   logic [N_REG-1:1] busy_d;

   // Reserve is applied after the clear so a same-cycle reserve and write
   // leaves the register busy (a newer producer is now pending).
   always_comb begin
      busy_d = busy_q;
      for (int unsigned r = 1; r < N_REG; r++) begin
         if (wr_clr_i[r]) busy_d[r] = 1'b0;
         if (rsv_en_i && (rsv_addr_i == N_REG_ADDR'(r))) busy_d[r] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   always_comb begin
      rd_busy_o = '0;
      for (int unsigned p = 0; p < N_READ; p++) begin
         for (int unsigned r = 1; r < N_REG; r++) begin
            if (rd_addr_i[p*N_REG_ADDR +: N_REG_ADDR] == N_REG_ADDR'(r)) begin
               rd_busy_o[p] = busy_q[r];
            end
         end
      end
   end

endmodule

// File: rtl/multiport_regfile.sv
// multiport_regfile
//   N_READ combinational read ports, N_WRITE synchronous write ports
//   (highest port index wins on conflict), hardwired-zero register 0,
//   register SP_IDX reset to SP_RESET, per-register busy scoreboard.
//   Optional feature macro: REGFILE_BYPASS_EN -- same-cycle write-to-read
//   forwarding (combinational wr_* -> rd_* path).
//   Ports:
//     clk       clock, all state updates on the rising edge
//     rst       synchronous active-high reset
//     rd_addr   N_READ x N_REG_ADDR read addresses
//     rd_data   N_READ x N_DATA read data
//     rd_busy   N_READ pending-result flags
//     wr_en     N_WRITE write enables
//     wr_addr   N_WRITE x N_REG_ADDR write addresses
//     wr_data   N_WRITE x N_DATA write data
//     rsv_en    reserve request
//     rsv_addr  register to reserve
module multiport_regfile
   import regfile_pkg::*;
#(
   parameter int unsigned N_REG_ADDR = DEF_N_REG_ADDR,
   parameter int unsigned N_REG      = DEF_N_REG,
   parameter int unsigned N_DATA     = DEF_N_DATA,
   parameter int unsigned N_READ     = 4,
   parameter int unsigned N_WRITE    = 2,
   parameter int unsigned SP_IDX     = DEF_SP_IDX,
   parameter int unsigned SP_RESET   = DEF_SP_RESET
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_READ*N_REG_ADDR-1:0]  rd_addr,
   output logic [N_READ*N_DATA-1:0]      rd_data,
   output logic [N_READ-1:0]             rd_busy,
   input  logic [N_WRITE-1:0]            wr_en,
   input  logic [N_WRITE*N_REG_ADDR-1:0] wr_addr,
   input  logic [N_WRITE*N_DATA-1:0]     wr_data,
   input  logic                          rsv_en,
   input  logic [N_REG_ADDR-1:0]         rsv_addr
);

   // Register 0 is not stored; the array starts at index 1.
   logic [N_DATA-1:0]  mem_q [N_REG-1:1];
   logic [N_DATA-1:0]  mem_d [N_REG-1:1];
   logic [N_REG-1:1]   wr_clr;
   logic [N_READ-1:0]  sb_busy;

   // Write resolution per register: collect matching enabled ports and take
   // the highest index. Addresses 0 and >= N_REG never match any entry.
   always_comb begin
      logic [MAX_WR_PORTS-1:0] hits;
      hits   = '0;
      wr_clr = '0;
      for (int unsigned r = 1; r < N_REG; r++) begin
         hits     = '0;
         mem_d[r] = mem_q[r];
         for (int unsigned p = 0; p < N_WRITE; p++) begin
            hits[p] = wr_en[p] && (wr_addr[p*N_REG_ADDR +: N_REG_ADDR] == N_REG_ADDR'(r));
         end
         if (|hits) begin
            wr_clr[r] = 1'b1;
            mem_d[r]  = wr_data[wr_winner(hits)*N_DATA +: N_DATA];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned r = 1; r < N_REG; r++) begin
            mem_q[r] <= (r == SP_IDX) ? N_DATA'(SP_RESET) : '0;
         end
      end else begin
         for (int unsigned r = 1; r < N_REG; r++) begin
            mem_q[r] <= mem_d[r];
         end
      end
   end

   regfile_scoreboard #(
      .N_REG_ADDR (N_REG_ADDR),
      .N_REG      (N_REG),
      .N_READ     (N_READ)
   ) u_scoreboard (
      .clk_i      (clk),
      .rst_i      (rst),
      .rsv_en_i   (rsv_en),
      .rsv_addr_i (rsv_addr),
      .wr_clr_i   (wr_clr),
      .rd_addr_i  (rd_addr),
      .rd_busy_o  (sb_busy)
   );

   // Read mux: stored value, or 0 for register 0 / out-of-range addresses.
   always_comb begin
      logic [N_REG_ADDR-1:0]   a;
      logic [N_DATA-1:0]       d;
`ifdef REGFILE_BYPASS_EN
      logic                    a_valid;
      logic [MAX_WR_PORTS-1:0] byp;
      a_valid = 1'b0;
      byp     = '0;
`endif
      a       = '0;
      d       = '0;
      rd_data = '0;
      rd_busy = '0;
      for (int unsigned p = 0; p < N_READ; p++) begin
         a = rd_addr[p*N_REG_ADDR +: N_REG_ADDR];
         d = '0;
`ifdef REGFILE_BYPASS_EN
         a_valid = 1'b0;
`endif
         for (int unsigned r = 1; r < N_REG; r++) begin
            if (a == N_REG_ADDR'(r)) begin
               d = mem_q[r];
`ifdef REGFILE_BYPASS_EN
               a_valid = 1'b1;
`endif
            end
         end
         rd_data[p*N_DATA +: N_DATA] = d;
         rd_busy[p]                  = sb_busy[p];
`ifdef REGFILE_BYPASS_EN
         // Forward the winning same-cycle write; writes are ignored under
         // reset, so forwarding is suppressed there too.
         byp = '0;
         for (int unsigned w = 0; w < N_WRITE; w++) begin
            byp[w] = !rst && a_valid && wr_en[w] &&
                     (wr_addr[w*N_REG_ADDR +: N_REG_ADDR] == a);
         end
         if (|byp) begin
            rd_data[p*N_DATA +: N_DATA] = wr_data[wr_winner(byp)*N_DATA +: N_DATA];
            rd_busy[p]                  = rsv_en && (rsv_addr == a);
         end
`endif
      end
   end

endmodule

// File: tb/tb_multiport_regfile.sv
// tb_multiport_regfile
//   Directed stimulus pushes expected read results into a queue; a monitor
//   on the falling edge pops and compares against the DUT read ports.
//   Expectations depend on REGFILE_BYPASS_EN where forwarding matters.
module tb_multiport_regfile;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned NR = 4;
   localparam int unsigned NW = 2;

   logic               clk;
   logic               rst;
   logic [NR*AW-1:0]   rd_addr;
   logic [NR*DW-1:0]   rd_data;
   logic [NR-1:0]      rd_busy;
   logic [NW-1:0]      wr_en;
   logic [NW*AW-1:0]   wr_addr;
   logic [NW*DW-1:0]   wr_data;
   logic               rsv_en;
   logic [AW-1:0]      rsv_addr;

   int unsigned        n_cmp;
   int unsigned        n_bad;

   int unsigned        q_port [$];
   logic [DW-1:0]      q_data [$];
   logic               q_busy [$];
   string              q_name [$];

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   multiport_regfile #(
      .N_REG_ADDR (AW),
      .N_REG      (32),
      .N_DATA     (DW),
      .N_READ     (NR),
      .N_WRITE    (NW),
      .SP_IDX     (2),
      .SP_RESET   (255)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en  = '0;
      rsv_en = 1'b0;
   endtask

   task automatic set_rd(input int unsigned p, input int unsigned a);
      rd_addr[p*AW +: AW] = AW'(a);
   endtask

   task automatic set_wr(input int unsigned p, input int unsigned a, input logic [DW-1:0] d);
      wr_en[p]            = 1'b1;
      wr_addr[p*AW +: AW] = AW'(a);
      wr_data[p*DW +: DW] = d;
   endtask

   task automatic expect_rd(input int unsigned p, input logic [DW-1:0] d, input logic b,
                            input string nm);
      q_port.push_back(p);
      q_data.push_back(d);
      q_busy.push_back(b);
      q_name.push_back(nm);
   endtask

   // Monitor: compares every queued expectation against the read ports.
   initial begin
      int unsigned   p;
      logic [DW-1:0] d;
      logic          b;
      string         nm;
      forever begin
         @(negedge clk);
         while (q_port.size() != 0) begin
            p  = q_port.pop_front();
            d  = q_data.pop_front();
            b  = q_busy.pop_front();
            nm = q_name.pop_front();
            n_cmp++;
            if (rd_data[p*DW +: DW] !== d) begin
               n_bad++;
               $display("FAIL %s data port%0d: got %h, want %h", nm, p, rd_data[p*DW +: DW], d);
            end
            n_cmp++;
            if (rd_busy[p] !== b) begin
               n_bad++;
               $display("FAIL %s busy port%0d: got %b, want %b", nm, p, rd_busy[p], b);
            end
         end
      end
   end

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      rst      = 1'b1;
      rd_addr  = '0;
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      rsv_en   = 1'b0;
      rsv_addr = '0;

      // Reset, with garbage writes/reserve that must be ignored.
      set_wr(0, 9, 32'h1111_1111);
      rsv_en = 1'b1; rsv_addr = 5'd9;
      step();
      idle();
      // Still in reset for one more cycle: outputs must already show reset state.
      for (int unsigned p = 0; p < NR; p++) set_rd(p, p);
      expect_rd(0, 32'd0, 1'b0, "rst_hold_r0");
      expect_rd(1, 32'd0, 1'b0, "rst_hold_r1");
      expect_rd(2, 32'd255, 1'b0, "rst_hold_sp");
      expect_rd(3, 32'd0, 1'b0, "rst_hold_r3");
      step();
      rst = 1'b0;

      // Read all 32 addresses over 8 cycles.
      for (int unsigned c = 0; c < 8; c++) begin
         for (int unsigned p = 0; p < NR; p++) begin
            set_rd(p, c*NR + p);
            expect_rd(p, (c*NR + p == 2) ? 32'd255 : 32'd0, 1'b0, "reset_scan");
         end
         step();
      end

      // Write conflict on reg 5: port 1 wins.
      set_wr(0, 5, 32'hDEAD_BEEF);
      set_wr(1, 5, 32'h0000_1234);
      set_rd(0, 5);
      expect_rd(0, BYP ? 32'h0000_1234 : 32'd0, 1'b0, "conflict_same");
      step();
      idle();
      expect_rd(0, 32'h0000_1234, 1'b0, "conflict_next");

      // Distinct addresses on both ports in one cycle.
      set_wr(0, 10, 32'hAAAA_0010);
      set_wr(1, 11, 32'hBBBB_0011);
      step();
      idle();
      set_rd(1, 10); set_rd(2, 11);
      expect_rd(1, 32'hAAAA_0010, 1'b0, "dual_wr_p0");
      expect_rd(2, 32'hBBBB_0011, 1'b0, "dual_wr_p1");
      step();

      // Register 0: write and reserve are discarded.
      set_wr(0, 0, 32'hFFFF_FFFF);
      rsv_en = 1'b1; rsv_addr = 5'd0;
      set_rd(1, 0);
      expect_rd(1, 32'd0, 1'b0, "zero_same");
      step();
      idle();
      expect_rd(1, 32'd0, 1'b0, "zero_next");

      // Reserve reg 7, two idle cycles of busy.
      rsv_en = 1'b1; rsv_addr = 5'd7;
      set_rd(2, 7);
      expect_rd(2, 32'd0, 1'b0, "rsv_same");
      step();
      idle();
      expect_rd(2, 32'd0, 1'b1, "rsv_idle1");
      step();
      expect_rd(2, 32'd0, 1'b1, "rsv_idle2");
      step();
      // Write reg 7 = 42 clears busy.
      set_wr(1, 7, 32'd42);
      expect_rd(2, BYP ? 32'd42 : 32'd0, BYP ? 1'b0 : 1'b1, "wr7_same");
      step();
      idle();
      expect_rd(2, 32'd42, 1'b0, "wr7_next");
      step();
      // Same-cycle reserve and write of reg 7: data stored, busy stays set.
      set_wr(0, 7, 32'd9);
      rsv_en = 1'b1; rsv_addr = 5'd7;
      expect_rd(2, BYP ? 32'd9 : 32'd42, BYP ? 1'b1 : 1'b0, "rsvwr_same");
      step();
      idle();
      expect_rd(2, 32'd9, 1'b1, "rsvwr_next");
      step();

      // Write reg 3 while reading it.
      set_wr(0, 3, 32'h0000_00A5);
      set_rd(3, 3);
      expect_rd(3, BYP ? 32'h0000_00A5 : 32'd0, 1'b0, "byp_same");
      step();
      idle();
      expect_rd(3, 32'h0000_00A5, 1'b0, "byp_next");
      step();

      // Write reg 2 = 0, reserve reg 4, then reset.
      set_wr(0, 2, 32'd0);
      rsv_en = 1'b1; rsv_addr = 5'd4;
      step();
      idle();
      set_rd(0, 2); set_rd(1, 4); set_rd(2, 5); set_rd(3, 7);
      expect_rd(0, 32'd0, 1'b0, "pre_rst_sp");
      expect_rd(1, 32'd0, 1'b1, "pre_rst_r4");
      step();
      rst = 1'b1;
      set_wr(1, 2, 32'h0000_0077);
      rsv_en = 1'b1; rsv_addr = 5'd5;
      step();
      rst = 1'b0;
      idle();
      expect_rd(0, 32'd255, 1'b0, "post_rst_sp");
      expect_rd(1, 32'd0, 1'b0, "post_rst_r4");
      expect_rd(2, 32'd0, 1'b0, "post_rst_r5");
      expect_rd(3, 32'd0, 1'b0, "post_rst_r7");
      step();

      // Bounded drain of the expectation queue.
      for (int unsigned i = 0; i < 5 && q_port.size() != 0; i++) step();
      if (q_port.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", q_port.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
